// File: rtl/dmem_responder.sv
// Purpose : data-memory slave answering MEM-stage load/store requests.
// Latency : completion pulse LATENCY+1 cycles after the request is first seen.
// Backpres: o_mem_busy high in BUSY/RESP; requests are not accepted until IDLE.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), synchronous active-high reset
//   i_mem_read/_write     level request strobes, sampled only in IDLE
//   i_mem_address         byte address; word index = address[ADDR_WIDTH-1:2]
//   i_mem_write_data      store data, lane-0 aligned
//   i_ins_func3           access size in [1:0]: 00=B 01=H 10=W 11=illegal
//   o_mem_read_data       raw word of the last successful load
//   o_mem_data_ok         one-cycle completion pulse (RESP state)
//   o_mem_busy            high while a request is in flight
//   o_mem_err             misaligned/illegal flag, only valid with o_mem_data_ok
//
// Optional: define DMEM_RAND_STALL_EN to add 0..3 pseudo-random extra BUSY
// cycles per request from an 8-bit LFSR (stall-robustness testing).
module dmem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,   // only 32 is supported
  parameter int LATENCY    = 1     // 1..15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  input  logic [DATA_WIDTH-1:0] i_mem_write_data,
  input  logic [2:0]            i_ins_func3,
  output logic [DATA_WIDTH-1:0] o_mem_read_data,
  output logic                  o_mem_data_ok,
  output logic                  o_mem_busy,
  output logic                  o_mem_err
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
  // Wide enough for LATENCY-1 plus up to 3 random extra cycles.
  localparam int CW = 5;
  localparam logic [CW-1:0] CNT_BASE = CW'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0]            r_size;
  logic                  r_rd;
  logic                  r_wr;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_err;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_lane;
  logic [ADDR_WIDTH-3:0] w_idx;
  logic                  w_access;
  logic [CW-1:0]         w_cnt_init;
  // func3[2] only selects sign/zero extension, which happens downstream.
  logic                  w_unused_f3;

  assign w_unused_f3 = i_ins_func3[2];
  assign w_idx       = r_addr[ADDR_WIDTH-1:2];
  assign w_access    = (r_state == S_BUSY) && (r_cnt == '0);

`ifdef DMEM_RAND_STALL_EN
  logic [7:0] r_lfsr;

  // Fibonacci LFSR, taps 8,6,5,4; free-running, reseeded on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_cnt_init = CNT_BASE + {3'b000, r_lfsr[1:0]};
`else
  assign w_cnt_init = CNT_BASE;
`endif

  // Error and lane decode work on the captured request, so input changes
  // after acceptance (including a flush) cannot affect the access.
  always_comb begin
    w_err  = 1'b0;
    w_be   = 4'b0000;
    w_lane = r_wdata;
    if (r_rd && r_wr) w_err = 1'b1;
    case (r_size)
      2'b00: begin
        w_be   = 4'b0001 << r_addr[1:0];
        w_lane = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = r_addr[1] ? 4'b1100 : 4'b0011;
        w_lane = {2{r_wdata[15:0]}};
        if (r_addr[0]) w_err = 1'b1;
      end
      2'b10: begin
        w_be = 4'b1111;
        if (r_addr[1:0] != 2'b00) w_err = 1'b1;
      end
      default: w_err = 1'b1;
    endcase
  end

  // RAM is not reset; a reset coinciding with the access edge aborts the store.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_access && r_wr && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= 2'b00;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_mem_read || i_mem_write) begin
            r_addr  <= i_mem_address;
            r_wdata <= i_mem_write_data;
            r_size  <= i_ins_func3[1:0];
            r_rd    <= i_mem_read;
            r_wr    <= i_mem_write;
            r_cnt   <= w_cnt_init;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_err <= w_err;
            if (r_rd && !w_err) r_rdata <= r_mem[w_idx];
            r_state <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_read_data = r_rdata;
  assign o_mem_data_ok   = (r_state == S_RESP);
  assign o_mem_busy      = (r_state == S_BUSY) || (r_state == S_RESP);
  // r_err may hold a stale value outside RESP; qualify it here.
  assign o_mem_err       = o_mem_data_ok && r_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int AW   = 12;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;
`ifdef DMEM_RAND_STALL_EN
  localparam int XS = 3;
`else
  localparam int XS = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (LATENCY=1), checked every cycle by the reference model.
  logic          rst = 1'b1, rd = 1'b0, wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic [2:0]    f3 = 3'b010;
  logic [31:0]   rdata;
  logic          ok, busy, err;

  // Second instance (LATENCY=3) for flush / long-latency timing.
  logic          rst3 = 1'b1, rd3 = 1'b0, wr3 = 1'b0;
  logic [AW-1:0] addr3 = '0;
  logic [31:0]   wdata3 = '0;
  logic [2:0]    f33 = 3'b010;
  logic [31:0]   rdata3;
  logic          ok3, busy3, err3;

  dmem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .LATENCY(LAT)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_mem_read(rd), .i_mem_write(wr),
    .i_mem_address(addr), .i_mem_write_data(wdata), .i_ins_func3(f3),
    .o_mem_read_data(rdata), .o_mem_data_ok(ok), .o_mem_busy(busy), .o_mem_err(err));

  dmem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .LATENCY(LAT3)) u_dut3 (
    .i_clk(clk), .i_rst(rst3), .i_mem_read(rd3), .i_mem_write(wr3),
    .i_mem_address(addr3), .i_mem_write_data(wdata3), .i_ins_func3(f33),
    .o_mem_read_data(rdata3), .o_mem_data_ok(ok3), .o_mem_busy(busy3), .o_mem_err(err3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Completion latency of the main instance, counted from the request cycle.
  task automatic chk_lat(input string name, input int lat);
    checks++;
`ifdef DMEM_RAND_STALL_EN
    if (lat < LAT + 1 || lat > LAT + 4) begin
      errors++;
      $display("FAIL %s: latency %0d expected %0d..%0d", name, lat, LAT + 1, LAT + 4);
    end
`else
    if (lat != LAT + 1) begin
      errors++;
      $display("FAIL %s: latency %0d expected %0d", name, lat, LAT + 1);
    end
`endif
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic bit is_err(bit r, bit w, logic [AW-1:0] a, logic [2:0] f);
    return (r && w) || (f[1:0] == 2'd3) || (f[1:0] == 2'd1 && a[0]) ||
           (f[1:0] == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [AW-1:0] a,
                                        logic [31:0] d, logic [1:0] sz);
    logic [31:0] r;
    r = old;
    case (sz)
      2'd0:    r[8*a[1:0] +: 8] = d[7:0];
      2'd1:    r[16*a[1] +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  bit            mon_en = 1'b0;
  int            cyc = 0;
  bit            m_busy = 1'b0;
  int            m_acc = 0;
  bit            m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wd;
  logic [2:0]    m_f3;
  logic [31:0]   m_mem [16];
  bit            m_mvld [16];
  logic [31:0]   m_rdata = '0;
  bit            m_rvld = 1'b1;

  always @(negedge clk) begin
    bit done;
    bit e;
    int lat;
    int idx;
    if (mon_en) begin
      cyc++;
      done = 1'b0;
      if (m_busy) begin
        lat = cyc - m_acc;
        chk("busy_in_flight", busy, 1'b1);
        if (ok === 1'b1) begin
          checks++;
          if (lat < LAT + 1 || lat > LAT + 1 + XS) begin
            errors++;
            $display("FAIL ok_window: pulse after %0d cycles expected %0d..%0d", lat, LAT + 1, LAT + 1 + XS);
          end
          done = 1'b1;
        end else begin
          chk("err_without_ok", err, 1'b0);
          if (lat >= LAT + 1 + XS) begin
            checks++;
            errors++;
            $display("FAIL ok_missing: no pulse %0d cycles after acceptance", lat);
            done = 1'b1;
          end
        end
        if (done) begin
          e   = is_err(m_rd, m_wr, m_addr, m_f3);
          idx = int'(m_addr[5:2]);
          if (ok === 1'b1) chk("err_flag", err, e);
          if (!e && m_rd) begin
            m_rdata = m_mem[idx];
            m_rvld  = m_mvld[idx];
          end
          if (!e && m_wr) begin
            m_mem[idx] = merge(m_mem[idx], m_addr, m_wd, m_f3[1:0]);
            if (m_f3[1:0] == 2'd2) m_mvld[idx] = 1'b1;
          end
          m_busy = 1'b0;
        end
      end else begin
        chk("ok_idle", ok, 1'b0);
        chk("busy_idle", busy, 1'b0);
        chk("err_idle", err, 1'b0);
        if ((rd || wr) && !rst) begin
          m_busy = 1'b1;
          m_acc  = cyc;
          m_rd   = rd;
          m_wr   = wr;
          m_addr = addr;
          m_wd   = wdata;
          m_f3   = f3;
        end
      end
      if (m_rvld) chk("read_data", rdata, m_rdata);
      if (rst) begin
        m_busy  = 1'b0;
        m_rdata = '0;
        m_rvld  = 1'b1;
      end
    end
  end

  // ---------------- directed request helper (main instance) ----------------
  task automatic run_req(input bit r, input bit w, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [2:0] f,
                         output logic [31:0] od, output logic oe, output int olat);
    int n;
    od = '0;
    oe = 1'b0;
    olat = -1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 50);
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy stuck high");
    end
    @(posedge clk); #1;
    rd = r; wr = w; addr = a; wdata = d; f3 = f;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ok === 1'b1) begin
        od = rdata;
        oe = err;
        olat = i;
        break;
      end
    end
    checks++;
    if (olat < 0) begin
      errors++;
      $display("FAIL ok_timeout: no completion for addr %h", a);
    end
  endtask

`ifdef DMEM_RAND_STALL_EN
  int lats_a [16];
  int lats_b [16];
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    int          okc;
    int          okcyc;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; rst3 = 1'b0; mon_en = 1'b1;

    // Reset state of both instances.
    @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ok", ok, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst3_rdata", rdata3, 32'h0);
    chk("rst3_busy", busy3, 1'b0);

    // Preload the 16-word test region with known data.
    for (int i = 0; i < 16; i++) begin
      run_req(1'b0, 1'b1, AW'(i * 4), $urandom, 3'b010, d, e, lat);
    end

    // Store word then load it back.
    run_req(1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 3'b010, d, e, lat);
    chk("t1_sw_err", e, 1'b0);
    chk_lat("t1_sw_lat", lat);
    run_req(1'b1, 1'b0, 12'h010, 32'h0, 3'b010, d, e, lat);
    chk("t1_lw_data", d, 32'hDEADBEEF);
    chk("t1_lw_err", e, 1'b0);
    chk_lat("t1_lw_lat", lat);

    // Byte and half-word lane merging; upper data bits must be ignored.
    run_req(1'b0, 1'b1, 12'h010, 32'h0, 3'b010, d, e, lat);
    run_req(1'b0, 1'b1, 12'h011, 32'h556677AA, 3'b000, d, e, lat);
    run_req(1'b0, 1'b1, 12'h012, 32'h99991234, 3'b001, d, e, lat);
    run_req(1'b1, 1'b0, 12'h010, 32'h0, 3'b010, d, e, lat);
    chk("t2_lw_merge", d, 32'h1234AA00);
    // Unsigned-byte load still returns the raw word.
    run_req(1'b1, 1'b0, 12'h013, 32'h0, 3'b100, d, e, lat);
    chk("t2_lbu_raw", d, 32'h1234AA00);
    chk("t2_lbu_err", e, 1'b0);

    // Error cases leave RAM and read data untouched.
    run_req(1'b0, 1'b1, 12'h004, 32'h55667788, 3'b010, d, e, lat);
    run_req(1'b0, 1'b1, 12'h006, 32'h0, 3'b010, d, e, lat);
    chk("t3_sw_misal_err", e, 1'b1);
    chk_lat("t3_err_lat", lat);
    run_req(1'b1, 1'b0, 12'h004, 32'h0, 3'b010, d, e, lat);
    chk("t3_lw_unchanged", d, 32'h55667788);
    chk("t3_lw_err", e, 1'b0);
    run_req(1'b1, 1'b0, 12'h004, 32'h0, 3'b011, d, e, lat);
    chk("t3_illegal_err", e, 1'b1);
    chk("t3_illegal_hold", d, 32'h55667788);
    run_req(1'b1, 1'b0, 12'h005, 32'h0, 3'b001, d, e, lat);
    chk("t3_lh_misal_err", e, 1'b1);
    run_req(1'b0, 1'b1, 12'h006, 32'h0000ABCD, 3'b001, d, e, lat);
    chk("t3_sh_ok", e, 1'b0);
    run_req(1'b1, 1'b1, 12'h004, 32'hFFFFFFFF, 3'b010, d, e, lat);
    chk("t3_rdwr_err", e, 1'b1);
    run_req(1'b1, 1'b0, 12'h004, 32'h0, 3'b010, d, e, lat);
    chk("t3_after_sh", d, 32'hABCD7788);

    // Reset during BUSY aborts a store.
    run_req(1'b0, 1'b1, 12'h020, 32'h11111111, 3'b010, d, e, lat);
    @(negedge clk);
    @(posedge clk); #1;
    wr = 1'b1; addr = 12'h020; wdata = 32'hFFFFFFFF; f3 = 3'b010;
    @(posedge clk); #1;
    wr = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rdata_zero", rdata, 32'h0);
    chk("t5_busy_zero", busy, 1'b0);
    okc = (ok === 1'b1) ? 1 : 0;
    repeat (6) begin
      @(negedge clk);
      if (ok === 1'b1) okc++;
    end
    chk("t5_no_ok", okc, 0);
    run_req(1'b1, 1'b0, 12'h020, 32'h0, 3'b010, d, e, lat);
    chk("t5_word_kept", d, 32'h11111111);

    // LATENCY=3 instance: load accepted, then flushed in cycle 1.
    @(posedge clk); #1;
    rd3 = 1'b1; addr3 = 12'h010; f33 = 3'b010;
    @(posedge clk); #1;
    rd3 = 1'b0;
    okc = 0;
    okcyc = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i <= 4) chk("t4_busy", busy3, 1'b1);
      if (ok3 === 1'b1) begin
        okc++;
        okcyc = i;
        chk("t4_err", err3, 1'b0);
      end
    end
    chk("t4_ok_count", okc, 1);
`ifdef DMEM_RAND_STALL_EN
    checks++;
    if (okcyc < LAT3 + 1 || okcyc > LAT3 + 4) begin
      errors++;
      $display("FAIL t4_ok_cycle: got %0d expected %0d..%0d", okcyc, LAT3 + 1, LAT3 + 4);
    end
`else
    chk("t4_ok_cycle", okcyc, LAT3 + 1);
    // A request held high is serviced again each time the FSM returns to IDLE.
    @(posedge clk); #1;
    rd3 = 1'b1;
    okc = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ok3 === 1'b1) okc++;
    end
    @(posedge clk); #1;
    rd3 = 1'b0;
    chk("t4_held_repeats", okc, 3);
`endif

    // Randomized traffic, checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) != 0) begin
        int v;
        v = $urandom_range(0, 15);
        rd = (v >= 6 && v <= 9) || v == 14;
        wr = (v >= 10 && v <= 13) || v == 14;
        addr = AW'({$urandom_range(0, 15), ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom)});
        wdata = $urandom;
        f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b010;
      end
    end
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0; rst = 1'b0;
    run_req(1'b1, 1'b0, 12'h000, 32'h0, 3'b010, d, e, lat);
    chk("rand_tail_err", e, 1'b0);

`ifdef DMEM_RAND_STALL_EN
    // Stall pattern must be reproducible from reset.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      run_req(1'b1, 1'b0, AW'(i * 4), 32'h0, 3'b010, d, e, lats_a[i]);
      chk_lat("t6_lat_a", lats_a[i]);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      run_req(1'b1, 1'b0, AW'(i * 4), 32'h0, 3'b010, d, e, lats_b[i]);
      chk("t6_repeat", lats_b[i], lats_a[i]);
    end
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
